// File: rtl/bitwise_logic_unit.sv
// Registered bitwise logic unit: eight bitwise ops on two WIDTH-bit operands,
// results delivered in order through a 2-entry buffer with zero/parity flags.
// Optional feature macro: BLU_STATS_EN adds the result_count output.
module bitwise_logic_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
`ifdef BLU_STATS_EN
  ,
  output logic [15:0]      result_count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] blu_op(input logic [2:0] sel,
                                              input logic [WIDTH-1:0] op_a,
                                              input logic [WIDTH-1:0] op_b);
    logic [WIDTH-1:0] r;
    case (sel)
      3'b000:  r = ~op_a;
      3'b001:  r = op_a & op_b;
      3'b010:  r = op_a | op_b;
      3'b011:  r = op_a ^ op_b;
      3'b100:  r = ~(op_a & op_b);
      3'b101:  r = ~(op_a | op_b);
      3'b110:  r = ~(op_a ^ op_b);
      default: r = op_a;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic             in_ready_q;
  logic             vld_p0, pop;
  logic             head_we, head_from_tail, tail_we;

  logic [WIDTH-1:0] y_p0;
  logic             zero_p0, par_p0;
  logic [WIDTH-1:0] head_y_p1, tail_y_p1;
  logic             head_zero_p1, tail_zero_p1;
  logic             head_par_p1, tail_par_p1;

  // Stage p0: result and flags computed combinationally from the offered beat
  assign y_p0    = blu_op(op, a, b);
  assign zero_p0 = ~|y_p0;
  assign par_p0  = ^y_p0;

  assign vld_p0 = in_valid && in_ready_q;
  assign pop    = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d        = state_q;
    head_we        = 1'b0;
    head_from_tail = 1'b0;
    tail_we        = 1'b0;
    case (state_q)
      EMPTY: begin
        if (vld_p0) begin
          head_we = 1'b1;
          state_d = ONE;
        end
      end
      ONE: begin
        if (vld_p0 && pop) begin
          head_we = 1'b1;
        end else if (vld_p0) begin
          tail_we = 1'b1;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only a pop can happen
        if (pop) begin
          head_from_tail = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // in_ready is a register so it never depends combinationally on out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // Stage p1: buffer storage; contents are qualified by state, so no reset
  always_ff @(posedge clk) begin
    if (head_we) begin
      head_y_p1    <= y_p0;
      head_zero_p1 <= zero_p0;
      head_par_p1  <= par_p0;
    end else if (head_from_tail) begin
      head_y_p1    <= tail_y_p1;
      head_zero_p1 <= tail_zero_p1;
      head_par_p1  <= tail_par_p1;
    end
    if (tail_we) begin
      tail_y_p1    <= y_p0;
      tail_zero_p1 <= zero_p0;
      tail_par_p1  <= par_p0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign y         = out_valid ? head_y_p1 : '0;
  assign zero      = out_valid ? head_zero_p1 : 1'b1;
  assign parity    = out_valid ? head_par_p1 : 1'b0;

`ifdef BLU_STATS_EN
  logic [15:0] result_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      result_count_q <= 16'd0;
    end else if (pop) begin
      result_count_q <= result_count_q + 16'd1;
    end
  end

  assign result_count = result_count_q;
`endif

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit: directed steps plus random traffic
// against a queue-based reference model of the in-order result buffer.
module tb_bitwise_logic_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       parity;
`ifdef BLU_STATS_EN
  logic [15:0] result_count;
  logic [15:0] m_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] q[$];
  logic       m_ready;
  logic       last_push;
  logic       last_pop;

  always #5 clk = ~clk;

  bitwise_logic_unit #(.WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y(y),
    .zero(zero),
    .parity(parity)
`ifdef BLU_STATS_EN
    ,
    .result_count(result_count)
`endif
  );

  function automatic logic [7:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    case (o)
      3'd0:    return 8'hFF - x;
      3'd1:    return x & z;
      3'd2:    return x | z;
      3'd3:    return x ^ z;
      3'd4:    return 8'hFF - (x & z);
      3'd5:    return 8'hFF - (x | z);
      3'd6:    return 8'hFF - (x ^ z);
      default: return x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs against the model, clock, then advance the model.
  task automatic cycle();
    logic push, pop;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, m_ready);
    if (q.size() > 0) begin
      chk("y", y, q[0]);
      chk("zero", zero, q[0] == 8'h00);
      chk("parity", parity, $countones(q[0]) % 2);
    end else begin
      chk("idle_y", y, 0);
      chk("idle_zero", zero, 1);
      chk("idle_parity", parity, 0);
    end
`ifdef BLU_STATS_EN
    chk("result_count", result_count, m_count);
`endif
    push = !rst && in_valid && m_ready;
    pop  = !rst && out_ready && (q.size() > 0);
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ready = 1'b0;
`ifdef BLU_STATS_EN
      m_count = 16'd0;
`endif
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(ref_op(op, a, b));
      m_ready = (q.size() < 2);
`ifdef BLU_STATS_EN
      if (pop) m_count = m_count + 16'd1;
`endif
    end
    last_push = push;
    last_pop  = pop;
    #1;
  endtask

  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] z);
    op = o; a = x; b = z; in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_push) break;
    end
    chk("send_accepted", last_push, 1);
    in_valid = 1'b0;
  endtask

  logic [7:0] sweep_tab [8];
  int pops;

  initial begin
    sweep_tab = '{8'h5A, 8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA5};
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; a = 8'h00; b = 8'h00;
    last_push = 1'b0; last_pop = 1'b0;
`ifdef BLU_STATS_EN
    m_count = 16'd0;
`endif
    @(posedge clk); #1;
    m_ready = 1'b0;

    // Reset state, then release
    cycle();
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    cycle();
    chk("post_rst_in_ready", in_ready, 1);

    // Opcode sweep with out_ready held high
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      op = 3'(k); a = 8'hA5; b = 8'h0F; in_valid = 1'b1;
      cycle();
      chk("sweep_y", y, sweep_tab[k]);
      chk("sweep_parity", parity, 0);
      chk("sweep_zero", zero, 0);
      chk("sweep_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    cycle();

    // Flags
    send(3'd3, 8'hFF, 8'hFF);
    chk("flag_xor_y", y, 8'h00);
    chk("flag_xor_zero", zero, 1);
    chk("flag_xor_parity", parity, 0);
    send(3'd7, 8'h01, 8'h00);
    chk("flag_pass_zero", zero, 0);
    chk("flag_pass_parity", parity, 1);
    cycle();

    // Backpressure: two accepts fill the buffer, third waits
    out_ready = 1'b0;
    send(3'($urandom), 8'($urandom), 8'($urandom));
    send(3'($urandom), 8'($urandom), 8'($urandom));
    chk("bp_full_in_ready", in_ready, 0);
    op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
    cycle();
    chk("bp_third_waits", last_push, 0);
    cycle();
    chk("bp_third_still_waits", last_push, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (last_push) break;
    end
    chk("bp_third_accepted", last_push, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Continuous stream of 10 beats with simultaneous push/pop
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom); in_valid = 1'b1;
      cycle();
      chk("stream_accept", last_push, 1);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    // Random traffic; an offered beat is held until accepted
    for (int i = 0; i < 400; i++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      end
      out_ready = 1'($urandom_range(0, 1));
      cycle();
      if (last_push) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Reset mid-stall with a full buffer and a beat offered during reset
    out_ready = 1'b0;
    send(3'd2, 8'h3C, 8'h81);
    send(3'd1, 8'hF0, 8'h77);
    chk("stall_full", in_ready, 0);
    rst = 1'b1; in_valid = 1'b1; op = 3'd7; a = 8'h99;
    cycle();
    chk("rst_stall_valid", out_valid, 0);
    chk("rst_stall_y", y, 8'h00);
    chk("rst_stall_zero", zero, 1);
    chk("rst_stall_in_ready", in_ready, 0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("rst_release_in_ready", in_ready, 1);
    chk("rst_no_stale", out_valid, 0);
    cycle();
    chk("rst_no_stale2", out_valid, 0);

`ifdef BLU_STATS_EN
    // Counter wrap: 65537 output handshakes after reset
    pops = 0;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      cycle();
      if (last_pop) pops++;
      if (pops == 65537) break;
    end
    in_valid = 1'b0;
    chk("stats_pops", pops, 65537);
    chk("stats_wrap", result_count, 16'h0001);
    for (int i = 0; i < 3; i++) cycle();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bitwise_logic_unit.md
# bitwise_logic_unit

Parametrised, registered bitwise logic unit: the multi-bit, multi-operation successor to the single-bit inverter in the Basics set. It accepts two WIDTH-bit operands and a 3-bit opcode over a valid/ready handshake, computes one of eight bitwise operations, and delivers results in order through a 2-entry output buffer with zero and parity flags. It sits between the operand-fetch stage and the ALU result mux of the CPU datapath.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1 to 64.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand/op beat valid
- in_ready  output  1  unit can accept a beat
- op  input  3  operation select, sampled with a and b
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B; ignored for single-operand ops
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- y  output  WIDTH  result
- zero  output  1  y == 0
- parity  output  1  XOR-reduction of y (1 = odd number of ones)

## Operation
- Opcodes: 000 NOT a; 001 a AND b; 010 a OR b; 011 a XOR b; 100 NAND; 101 NOR; 110 XNOR; 111 PASS a.
- Input handshake: a beat is accepted on a rising edge with in_valid && in_ready. Output handshake: a beat is consumed on a rising edge with out_valid && out_ready.
- Result, zero and parity are computed combinationally from the accepted beat and written into the buffer together; flags always describe the stored y.
- The buffer is a 2-entry in-order queue with states EMPTY (0 entries), ONE (1 entry) and FULL (2 entries).
- in_ready = 1 in EMPTY and ONE, and 0 in FULL. in_ready is registered, not combinationally dependent on out_ready.
- out_valid = 1 in ONE and FULL. y, zero and parity present the head entry.
- State transitions:
  - EMPTY: push goes to ONE.
  - ONE: push only goes to FULL; pop only goes to EMPTY; simultaneous push and pop stays in ONE, with the new beat becoming the head on the next cycle.
  - FULL: pop goes to ONE, and the second entry moves to the head. No push is possible.
- When out_valid is 1 and out_ready is 0, y, zero and parity hold stable.
- Results are never dropped, duplicated or reordered.

## Timing
- Latency: a beat accepted at edge N is visible on y with out_valid = 1 after edge N (cycle N+1), provided the buffer was EMPTY.
- Throughput: 1 beat per cycle while out_ready is held high.
- Reset, applied at any edge where rst = 1:
  - State goes to EMPTY.
  - out_valid = 0, y = 0, zero = 1, parity = 0.
  - in_ready = 0 while rst is high and 1 on the first cycle after rst deasserts.
  - Buffered entries are discarded, including mid-stall.
  - Inputs are ignored during reset.
- in_valid asserted while in_ready = 0 has no effect. The source must hold the beat stable until it is accepted.

## Configuration
- BLU_STATS_EN defined:
  - Adds output result_count [15:0], the count of output handshakes.
  - Increments by 1 on each out_valid && out_ready edge and wraps from 0xFFFF to 0x0000.
  - Reset value is 0.
  - Has no effect on the datapath or handshake.
- BLU_STATS_EN undefined: the port and counter are absent, and all other behaviour is identical.

## Test plan
- Opcode sweep, WIDTH = 8, out_ready held 1: a = 0xA5, b = 0x0F, op 000 to 111 sequentially. Required y: 0x5A, 0x05, 0xAF, 0xAA, 0xFA, 0x50, 0x55, 0xA5, each 1 cycle after acceptance. Required parity: 0, 0, 0, 0, 0, 0, 0, 0. Required zero: 0 throughout.
- Backpressure: out_ready = 0, three consecutive beats offered. Required: in_ready drops after 2 accepts and the third beat waits. Then out_ready = 1 yields all three results in order at 1 per cycle.
- Simultaneous push/pop in ONE: continuous stream with out_ready = 1 for 10 beats. Required: in_ready stays 1, out_valid stays 1 from cycle 1, and 10 results emerge in order.
- Flags: a = b = 0xFF with XOR gives y = 0x00, zero = 1, parity = 0. a = 0x01 with PASS gives zero = 0, parity = 1.
- Reset mid-stall: buffer FULL, rst = 1 for 1 cycle. Required: out_valid = 0, y = 0, zero = 1, in_ready = 0 during reset and 1 afterwards. No stale results appear.
- With BLU_STATS_EN defined: after 65,537 output handshakes, result_count = 0x0001.
